// File: rtl/return_address_stack_mc.sv
// Circular return-address stack with a queue of repair checkpoints, so that
// several speculative branches can be outstanding and each can be undone.
module return_address_stack_mc #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 16,
   parameter int CHECKPOINTS = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [XLEN-1:0]                  address_in,
   input  logic                             push,
   input  logic                             pop,
   input  logic                             checkpoint,
   output logic [$clog2(CHECKPOINTS)-1:0]   cp_tag,
   output logic                             cp_available,
   input  logic                             resolve,
   input  logic [$clog2(CHECKPOINTS)-1:0]   resolve_tag,
   input  logic                             restore,
   input  logic [$clog2(CHECKPOINTS)-1:0]   restore_tag,
   output logic [XLEN-1:0]                  address_out,
   output logic                             empty,
   output logic                             full,
   output logic [$clog2(DEPTH):0]           n_entries,
   output logic [$clog2(CHECKPOINTS):0]     cp_count
);

   localparam int SP_W = $clog2(DEPTH);
   localparam int N_W  = SP_W + 1;
   localparam int T_W  = $clog2(CHECKPOINTS);
   localparam int C_W  = T_W + 1;

   typedef struct packed {
      logic [SP_W-1:0] sp;
      logic [N_W-1:0]  n;
      logic [XLEN-1:0] top;
   } cp_slot_t;

   // Stack state
   logic [XLEN-1:0] stack_q [DEPTH];
   logic [SP_W-1:0] sp_q, sp_d;
   logic [N_W-1:0]  n_q, n_d;
   logic            mem_we;
   logic [SP_W-1:0] mem_waddr;
   logic [XLEN-1:0] mem_wdata;

   // Checkpoint state
   cp_slot_t               slot_q [CHECKPOINTS];
   logic                   slot_we;
   cp_slot_t               slot_wdata;
   logic [CHECKPOINTS-1:0] live_q, live_d;
   logic [T_W-1:0]         head_q, head_d;
   logic [T_W-1:0]         tail_q, tail_d;
   logic [C_W-1:0]         cnt_q, cnt_d;

   logic [SP_W-1:0] sp_m1;
   logic [XLEN-1:0] top;
   logic            is_empty;
   logic            is_full;
   logic            can_alloc;
   logic            restore_hit;
   cp_slot_t        restore_slot;

   // Position of a slot in the queue relative to head (0 = oldest).
   function automatic logic [T_W-1:0] age_of(input logic [T_W-1:0] idx,
                                             input logic [T_W-1:0] h);
      return idx - h;
   endfunction

   assign sp_m1        = sp_q - SP_W'(1);
   assign top          = stack_q[sp_m1];
   assign is_empty     = (n_q == '0);
   assign is_full      = (n_q == N_W'(DEPTH));
   assign can_alloc    = (cnt_q != C_W'(CHECKPOINTS));
   assign restore_hit  = restore && live_q[restore_tag];
   assign restore_slot = slot_q[restore_tag];

   assign address_out  = top;
   assign empty        = is_empty;
   assign full         = is_full;
   assign n_entries    = n_q;
   assign cp_tag       = tail_q;
   assign cp_available = can_alloc;
   assign cp_count     = cnt_q;

   // ---------------------------------------------------------------
   // Stack next state and the single write port into the entry array
   // ---------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
      sp_d      = sp_q;
      n_d       = n_q;
      mem_we    = 1'b0;
      mem_waddr = sp_q;
      mem_wdata = address_in;

      if (restore_hit) begin
         // Rewriting the saved top repairs an entry clobbered after the checkpoint.
         sp_d      = restore_slot.sp;
         n_d       = restore_slot.n;
         mem_we    = 1'b1;
         mem_waddr = restore_slot.sp - SP_W'(1);
         mem_wdata = restore_slot.top;
      end else if (push && pop && !is_empty) begin
         mem_we    = 1'b1;
         mem_waddr = sp_m1;
      end else if (push) begin
         mem_we    = 1'b1;
         mem_waddr = sp_q;
         sp_d      = sp_q + SP_W'(1);
         if (!is_full) n_d = n_q + N_W'(1);
      end else if (pop && !is_empty) begin
         sp_d = sp_m1;
         n_d  = n_q - N_W'(1);
      end
   end

   // ---------------------------------------------------------------
   // Checkpoint queue: allocate, resolve, restore, then retire head
   // ---------------------------------------------------------------
   always_comb begin
      logic [T_W-1:0] h;
      logic [C_W-1:0] c;
      logic           stop;

      live_d     = live_q;
      tail_d     = tail_q;
      slot_we    = 1'b0;
      slot_wdata = '{sp: sp_q, n: n_q, top: top};
      c          = cnt_q;

      if (restore_hit) begin
         for (int i = 0; i < CHECKPOINTS; i++) begin
            if (age_of(T_W'(i), head_q) >= age_of(restore_tag, head_q)) live_d[i] = 1'b0;
         end
         if (resolve && live_q[resolve_tag] &&
             (age_of(resolve_tag, head_q) < age_of(restore_tag, head_q)))
            live_d[resolve_tag] = 1'b0;
         tail_d = restore_tag;
         c      = C_W'(age_of(restore_tag, head_q));
      end else begin
         if (resolve) live_d[resolve_tag] = 1'b0;
         if (checkpoint && can_alloc) begin
            slot_we        = 1'b1;
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + T_W'(1);
            c              = cnt_q + C_W'(1);
         end
      end

      // Retire resolved slots at the head, stopping at the first live one.
      h    = head_q;
      stop = 1'b0;
      for (int k = 0; k < CHECKPOINTS; k++) begin
         if (!stop) begin
            if ((c != '0) && !live_d[h]) begin
               h = h + T_W'(1);
               c = c - C_W'(1);
            end else begin
               stop = 1'b1;
            end
         end
      end
      head_d = h;
      cnt_d  = c;
   end

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the entry array is reset because address_out reads it directly and must show 0 after reset.
         for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
         for (int i = 0; i < CHECKPOINTS; i++) slot_q[i] <= '0;
         sp_q   <= '0;
         n_q    <= '0;
         live_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge state.
         if (mem_we)  stack_q[mem_waddr] <= mem_wdata;
         if (slot_we) slot_q[tail_q]     <= slot_wdata;
         sp_q   <= sp_d;
         n_q    <= n_d;
         live_q <= live_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   a_n_bound: assert property (@(posedge clk) disable iff (reset) n_q <= N_W'(DEPTH));
   a_cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt_q <= C_W'(CHECKPOINTS));

endmodule

// File: tb/tb_return_address_stack_mc.sv
// Directed bench: the driver queues hand-computed expectations, a monitor
// compares them against the outputs on the falling edge or on demand.
module tb_return_address_stack_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address_in;
   logic        push, pop, checkpoint, resolve, restore;
   logic [1:0]  resolve_tag, restore_tag;
   logic [1:0]  cp_tag;
   logic        cp_available;
   logic [31:0] address_out;
   logic        empty, full;
   logic [4:0]  n_entries;
   logic [2:0]  cp_count;

   return_address_stack_mc #(.XLEN(32), .DEPTH(16), .CHECKPOINTS(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .address_in  (address_in),
      .push        (push),
      .pop         (pop),
      .checkpoint  (checkpoint),
      .cp_tag      (cp_tag),
      .cp_available(cp_available),
      .resolve     (resolve),
      .resolve_tag (resolve_tag),
      .restore     (restore),
      .restore_tag (restore_tag),
      .address_out (address_out),
      .empty       (empty),
      .full        (full),
      .n_entries   (n_entries),
      .cp_count    (cp_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    addr;
      int    n;
      int    tag;
      int    cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   event async_chk;

   task automatic check(input string name, input int act, input int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
   endtask

   // Monitor: pops one expectation per falling edge (or on an async request).
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or async_chk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({e.name, " address_out"},  int'(address_out),  e.addr);
            check({e.name, " n_entries"},    int'(n_entries),    e.n);
            check({e.name, " empty"},        int'(empty),        int'(e.n == 0));
            check({e.name, " full"},         int'(full),         int'(e.n == 16));
            check({e.name, " cp_tag"},       int'(cp_tag),       e.tag);
            check({e.name, " cp_count"},     int'(cp_count),     e.cnt);
            check({e.name, " cp_available"}, int'(cp_available), int'(e.cnt != 4));
         end
      end
   end

   task automatic expect_state(input string name, input int a, input int n, input int t, input int c);
      exp_t e;
      e.name = name; e.addr = a; e.n = n; e.tag = t; e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic idle_inputs();
      push = 0; pop = 0; checkpoint = 0; resolve = 0; restore = 0;
      address_in = '0; resolve_tag = '0; restore_tag = '0;
   endtask

   // One clocked operation followed by the state expected after the edge.
   task automatic step(input string name, input logic ps, input logic pp, input logic [31:0] a,
                       input logic cp, input logic rv, input logic [1:0] rvt,
                       input logic rs, input logic [1:0] rst_t,
                       input int ea, input int en, input int et, input int ec);
      push = ps; pop = pp; address_in = a; checkpoint = cp;
      resolve = rv; resolve_tag = rvt; restore = rs; restore_tag = rst_t;
      @(posedge clk);
      #1;
      idle_inputs();
      expect_state(name, ea, en, et, ec);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      expect_state("reset", 0, 0, 0, 0);

      // 1: basic push/pop and pop on empty
      step("t1_push100", 1,0,32'h100, 0,0,0,0,0, 'h100, 1, 0, 0);
      step("t1_push200", 1,0,32'h200, 0,0,0,0,0, 'h200, 2, 0, 0);
      step("t1_push300", 1,0,32'h300, 0,0,0,0,0, 'h300, 3, 0, 0);
      step("t1_pop1",    0,1,0,       0,0,0,0,0, 'h200, 2, 0, 0);
      step("t1_pop2",    0,1,0,       0,0,0,0,0, 'h100, 1, 0, 0);
      step("t1_pop3",    0,1,0,       0,0,0,0,0, 0,     0, 0, 0);
      step("t1_pop4",    0,1,0,       0,0,0,0,0, 0,     0, 0, 0);

      // 2: overflow wraps and overwrites the oldest entry
      for (int k = 1; k <= 17; k++)
         step($sformatf("t2_push%0d", k), 1,0,k, 0,0,0,0,0, k, (k > 16) ? 16 : k, 0, 0);
      for (int j = 1; j <= 15; j++)
         step($sformatf("t2_pop%0d", j), 0,1,0, 0,0,0,0,0, 17 - j, 16 - j, 0, 0);
      step("t2_pop16", 0,1,0, 0,0,0,0,0, 17, 0, 0, 0);

      // 3: restore repairs an overwritten top entry
      step("t3_pushA",    1,0,32'hA000, 0,0,0,0,0, 'hA000, 1, 0, 0);
      step("t3_cp",       0,0,0,        1,0,0,0,0, 'hA000, 1, 1, 1);
      step("t3_pop",      0,1,0,        0,0,0,0,0, 17,     0, 1, 1);
      step("t3_pushB",    1,0,32'hB000, 0,0,0,0,0, 'hB000, 1, 1, 1);
      step("t3_restore0", 0,0,0,        0,0,0,1,0, 'hA000, 1, 0, 0);

      // 4: allocate all slots, overflow is ignored, out-of-order resolve
      step("t4_cp0",   0,0,0, 1,0,0,0,0, 'hA000, 1, 1, 1);
      step("t4_cp1",   0,0,0, 1,0,0,0,0, 'hA000, 1, 2, 2);
      step("t4_cp2",   0,0,0, 1,0,0,0,0, 'hA000, 1, 3, 3);
      step("t4_cp3",   0,0,0, 1,0,0,0,0, 'hA000, 1, 0, 4);
      step("t4_cp4x",  0,0,0, 1,0,0,0,0, 'hA000, 1, 0, 4);
      step("t4_res1",  0,0,0, 0,1,1,0,0, 'hA000, 1, 0, 4);
      step("t4_res0",  0,0,0, 0,1,0,0,0, 'hA000, 1, 0, 2);
      step("t4_res2",  0,0,0, 0,1,2,0,0, 'hA000, 1, 0, 1);
      step("t4_res3",  0,0,0, 0,1,3,0,0, 'hA000, 1, 0, 0);

      // 5: nested checkpoints, restore middle tag with push/cp ignored
      step("t5_push11", 1,0,32'h11, 0,0,0,0,0, 'h11, 2, 0, 0);
      step("t5_cp0",    0,0,0,      1,0,0,0,0, 'h11, 2, 1, 1);
      step("t5_push22", 1,0,32'h22, 0,0,0,0,0, 'h22, 3, 1, 1);
      step("t5_cp1",    0,0,0,      1,0,0,0,0, 'h22, 3, 2, 2);
      step("t5_push33", 1,0,32'h33, 0,0,0,0,0, 'h33, 4, 2, 2);
      step("t5_cp2",    0,0,0,      1,0,0,0,0, 'h33, 4, 3, 3);
      step("t5_pop",    0,1,0,      0,0,0,0,0, 'h22, 3, 3, 3);
      step("t5_pushpop",1,1,32'h44, 0,0,0,0,0, 'h44, 3, 3, 3);
      step("t5_rest1",  1,0,32'h55, 1,0,0,1,1, 'h22, 3, 1, 1);
      step("t5_pop2",   0,1,0,      0,0,0,0,0, 'h11, 2, 1, 1);
      step("t5_rest_nl",1,0,32'h66, 0,0,0,1,2, 'h66, 3, 1, 1);
      step("t5_cp1b",   0,0,0,      1,0,0,0,0, 'h66, 3, 2, 2);
      step("t5_rest_res",0,1,0,     0,1,0,1,1, 'h66, 3, 1, 0);

      // 6: asynchronous reset in the middle of a push burst
      step("t6_push77", 1,0,32'h77, 0,0,0,0,0, 'h77, 4, 1, 0);
      push = 1'b1; address_in = 32'h88;
      @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      expect_state("t6_async", 0, 0, 0, 0);
      -> async_chk;
      @(posedge clk);
      #1;
      idle_inputs();
      reset = 1'b0;
      step("t6_idle",   0,0,0,      0,0,0,0,0, 0,    0, 0, 0);
      step("t6_push99", 1,0,32'h99, 0,0,0,0,0, 'h99, 1, 0, 0);

      repeat (3) @(negedge clk);
      check("drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
